// File: rtl/fp_norm_round.sv
// Two-stage elastic normalise/round/pack stage for the FP adder (round-to-nearest-even).
// Define FP_SUBNORMAL_EN for gradual underflow; otherwise tiny results flush to signed zero.
module fp_norm_round #(
  parameter int E_WIDTH = 8,
  parameter int M_WIDTH = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sign,
  input  logic [E_WIDTH-1:0]         in_exp,
  input  logic [M_WIDTH+4:0]         in_mant,
  input  logic [1:0]                 in_class,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [E_WIDTH+M_WIDTH:0]   res
);

  localparam int EW = E_WIDTH + 2;
  localparam int SW = $clog2(M_WIDTH + 2) + 1;
  localparam int W  = E_WIDTH + M_WIDTH + 1;

  localparam logic [1:0] CLS_ZERO = 2'b01;
  localparam logic [1:0] CLS_INF  = 2'b10;
  localparam logic [1:0] CLS_NAN  = 2'b11;

  typedef logic signed [EW-1:0] sexp_t;

  localparam sexp_t EXP_MAX = sexp_t'((1 << E_WIDTH) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {E_WIDTH{1'b1}}, 1'b1, {(M_WIDTH-1){1'b0}}};

  logic              s1_valid, s2_valid;
  logic              s2_adv, s1_adv;
  logic              s1_sign, s1_shr, s1_sub, s1_flush, s1_zero;
  logic [1:0]        s1_class;
  logic [M_WIDTH+4:0] s1_mant;
  logic [SW-1:0]     s1_amt;
  sexp_t             s1_exp;

  logic [SW-1:0]     lz, c_amt;
  sexp_t             exp_in, exp_norm, c_exp;
  logic              c_shr, c_sub, c_flush;

  logic [M_WIDTH+3:0] m;
  logic               inc;
  logic [M_WIDTH+1:0] sig;
  logic [M_WIDTH-1:0] frac;
  sexp_t              fexp;
  logic [W-1:0]       packed_res;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = rst && s1_adv;
  assign out_valid = s2_valid;

  // Stage 1: leading-zero count below the carry and choice of shift/exponent.
  always_comb begin
    lz = SW'(M_WIDTH + 1);
    for (int i = 0; i <= M_WIDTH; i++)
      if (in_mant[3+i]) lz = SW'(M_WIDTH - i);
    exp_in   = sexp_t'({2'b00, in_exp});
    exp_norm = exp_in - sexp_t'(lz);
    c_shr    = 1'b0;
    c_amt    = lz;
    c_exp    = exp_norm;
    c_sub    = 1'b0;
    c_flush  = 1'b0;
    if (in_mant[M_WIDTH+4]) begin
      c_shr = 1'b1;
      c_amt = '0;
      c_exp = exp_in + sexp_t'(1);
    end else if (exp_norm <= 0) begin
`ifdef FP_SUBNORMAL_EN
      c_sub = 1'b1;
      c_exp = sexp_t'(1);
      if (in_exp == '0) begin
        c_shr = 1'b1;
        c_amt = '0;
      end else begin
        c_amt = SW'(in_exp - 1'b1);
      end
`else
      c_flush = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign  <= in_sign;
        s1_class <= in_class;
        s1_mant  <= in_mant;
        s1_zero  <= (in_mant == '0);
        s1_shr   <= c_shr;
        s1_amt   <= c_amt;
        s1_exp   <= c_exp;
        s1_sub   <= c_sub;
        s1_flush <= c_flush;
      end
    end
  end

  // Stage 2: a subnormal keeps exponent 1 in flight; the packed field is its hidden bit after rounding.
  always_comb begin
    if (s1_shr) m = {s1_mant[M_WIDTH+4:2], |s1_mant[1:0]};
    else        m = s1_mant[M_WIDTH+3:0] << s1_amt;
    inc  = m[2] & (m[1] | m[0] | m[3]);
    sig  = {1'b0, m[M_WIDTH+3:3]} + (M_WIDTH+2)'(inc);
    frac = sig[M_WIDTH+1] ? '0 : sig[M_WIDTH-1:0];
    if (s1_sub)                fexp = sig[M_WIDTH] ? sexp_t'(1) : sexp_t'(0);
    else if (sig[M_WIDTH+1])   fexp = s1_exp + sexp_t'(1);
    else                       fexp = s1_exp;
    packed_res = {s1_sign, fexp[E_WIDTH-1:0], frac};
    case (s1_class)
      CLS_ZERO: packed_res = {s1_sign, {(W-1){1'b0}}};
      CLS_INF:  packed_res = {s1_sign, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
      CLS_NAN:  packed_res = QNAN;
      default: begin
        if (s1_zero)             packed_res = '0;
        else if (s1_flush)       packed_res = {s1_sign, {(W-1){1'b0}}};
        else if (fexp >= EXP_MAX) packed_res = {s1_sign, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid <= 1'b0;
      res      <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) res <= packed_res;
    end
  end

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round at E=8, M=23: exact-arithmetic model, scoreboard and literal vectors.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [27:0] in_mant = '0;
  logic [1:0]  in_class = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;

  logic [31:0] expq[$];
  logic        holdValid = 1'b0;
  logic [31:0] holdRes = '0;
  int          postResetOutputs = 0;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [27:0] m;
    logic [1:0]  c;
    logic [31:0] want;
  } vec_t;

  fp_norm_round #(.E_WIDTH(8), .M_WIDTH(23)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_class(in_class),
    .out_valid(out_valid), .out_ready(out_ready), .res(res)
  );

  always #5 clk = ~clk;

  // Treats the mantissa as an exact integer scaled by 2^(exp-bias-26) and rounds that value to nearest-even.
  function automatic logic [31:0] model(input logic s, input logic [7:0] e,
                                        input logic [27:0] m, input logic [1:0] c);
    longint v, q, rem, half;
    int h, ne, sh;
    if (c == 2'b11) return 32'h7FC00000;
    if (c == 2'b10) return {s, 8'hFF, 23'h0};
    if (c == 2'b01) return {s, 31'h0};
    if (m == 28'h0) return 32'h0;
    v = longint'(m);
    h = 0;
    for (int i = 0; i < 28; i++) if (m[i]) h = i;
    ne = int'(e) + h - 26;
    if (ne >= 1) begin
      sh = h - 23;
    end else begin
`ifdef FP_SUBNORMAL_EN
      sh = 4 - int'(e);
      ne = 0;
`else
      return {s, 31'h0};
`endif
    end
    if (sh > 0) begin
      q    = v >>> sh;
      rem  = v - (q <<< sh);
      half = 64'sd1 <<< (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
    end else begin
      q = v <<< (-sh);
    end
    if (ne == 0) return {s, 31'(q)};
    if (q == (64'sd1 <<< 24)) begin
      q = q >>> 1;
      ne++;
    end
    if (ne >= 255) return {s, 8'hFF, 23'h0};
    return {s, ne[7:0], q[22:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic setBeat(input logic s, input logic [7:0] e, input logic [27:0] m, input logic [1:0] c);
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    in_class = c;
  endtask

  // Drives one beat and holds it until accepted, with a bounded wait.
  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [27:0] m, input logic [1:0] c);
    bit ok;
    ok = 1'b0;
    setBeat(s, e, m, c);
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL accept timeout: got in_ready 0, expected 1");
    end
  endtask

  task automatic waitOutput(output logic [31:0] r, output bit ok);
    ok = 1'b0;
    r  = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) begin
        r  = res;
        ok = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every output transfer must match the model value of the next accepted input.
  always @(negedge clk) begin
    if (!rst) begin
      expq.delete();
      holdValid = 1'b0;
    end else begin
      if (holdValid) begin
        checks++;
        if (!out_valid || res !== holdRes) begin
          errors++;
          $display("[TB] FAIL hold: got valid %0b res %h, expected valid 1 res %h", out_valid, res, holdRes);
        end
      end
      holdValid = out_valid && !out_ready;
      holdRes   = res;
      if (out_valid) postResetOutputs++;
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("[TB] FAIL scoreboard: got unexpected result %h, expected no output", res);
        end else begin
          logic [31:0] w;
          w = expq.pop_front();
          if (res !== w) begin
            errors++;
            $display("[TB] FAIL scoreboard: got %h, expected %h", res, w);
          end
        end
      end
      if (in_valid && in_ready) expq.push_back(model(in_sign, in_exp, in_mant, in_class));
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t  vecs[13];
    string names[13];
    logic [31:0] r;
    bit ok;
    int idx, acc;

    names[0]  = "identity";   vecs[0]  = '{0, 8'd127, 28'd1 << 26, 2'b00, 32'h3F800000};
    names[1]  = "carry";      vecs[1]  = '{0, 8'd127, 28'd1 << 27, 2'b00, 32'h40000000};
    names[2]  = "leftnorm";   vecs[2]  = '{0, 8'd127, 28'd1 << 24, 2'b00, 32'h3E800000};
    names[3]  = "cancel";     vecs[3]  = '{1, 8'd127, 28'd0,       2'b00, 32'h00000000};
    names[4]  = "rne_odd";    vecs[4]  = '{0, 8'd127, (28'd1 << 26) | (28'd1 << 3) | (28'd1 << 2), 2'b00, 32'h3F800002};
    names[5]  = "rne_even";   vecs[5]  = '{0, 8'd127, (28'd1 << 26) | (28'd1 << 2), 2'b00, 32'h3F800000};
    names[6]  = "rne_sticky"; vecs[6]  = '{0, 8'd127, (28'd1 << 26) | (28'd1 << 2) | 28'd1, 2'b00, 32'h3F800001};
    names[7]  = "overflow";   vecs[7]  = '{0, 8'd254, 28'd1 << 27, 2'b00, 32'h7F800000};
    names[8]  = "inf";        vecs[8]  = '{1, 8'd0,   28'd0,       2'b10, 32'hFF800000};
    names[9]  = "nan";        vecs[9]  = '{0, 8'd0,   28'd0,       2'b11, 32'h7FC00000};
    names[10] = "zero";       vecs[10] = '{1, 8'd0,   28'd0,       2'b01, 32'h80000000};
`ifdef FP_SUBNORMAL_EN
    names[11] = "underflow";  vecs[11] = '{0, 8'd1,   28'd1 << 25, 2'b00, 32'h00400000};
`else
    names[11] = "underflow";  vecs[11] = '{0, 8'd1,   28'd1 << 25, 2'b00, 32'h00000000};
`endif
    names[12] = "roundcarry"; vecs[12] = '{0, 8'd127, 28'h7FFFFFC, 2'b00, 32'h40000000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("reset res", res, 32'h0);
    checkOutput("reset in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("ready after reset", {31'h0, in_ready}, 32'h1);

    // Latency: output visible after the second edge counted from the accepting edge
    @(posedge clk);
    #1;
    setBeat(0, 8'd127, 28'd1 << 26, 2'b00);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("latency edge1 valid", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("latency edge2 valid", {31'h0, out_valid}, 32'h1);
    checkOutput("latency edge2 res", res, 32'h3F800000);
    @(posedge clk);
    #1;

    // Directed literal vectors, also pinning the model
    for (int i = 0; i < 13; i++) begin
      checkOutput({names[i], " model"}, model(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].c), vecs[i].want);
      applyStimulus(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].c);
      waitOutput(r, ok);
      checkOutput({names[i], " valid"}, {31'h0, ok}, 32'h1);
      checkOutput(names[i], r, vecs[i].want);
    end

    // Underflow boundary sweep, streamed back-to-back through the scoreboard
    in_valid = 1'b1;
    for (int e = 0; e < 5; e++) begin
      for (int l = 0; l < 4; l++) begin
        setBeat(1'(l & 1), 8'(e), (28'd1 << (26 - l)) | 28'd5, 2'b00);
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: only two beats fit while the consumer stalls
    out_ready = 1'b0;
    idx = 0;
    setBeat(0, 8'd100, (28'd1 << 26) | 28'd8, 2'b00);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      acc = int'(in_ready);
      @(posedge clk);
      #1;
      if (acc != 0) begin
        idx++;
        setBeat(0, 8'(100 + idx), (28'd1 << 26) | 28'(8 * (idx + 1)), 2'b00);
      end
    end
    checkOutput("bp accepted", 32'(idx), 32'd2);
    @(negedge clk);
    checkOutput("bp in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
      @(negedge clk);
      acc = int'(in_ready);
      @(posedge clk);
      #1;
      if (acc != 0) begin
        idx++;
        setBeat(0, 8'(100 + idx), (28'd1 << 26) | 28'(8 * (idx + 1)), 2'b00);
      end
    end
    in_valid = 1'b0;
    checkOutput("bp all accepted", 32'(idx), 32'd4);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("bp drained", 32'(expq.size()), 32'd0);

    // Reset in the middle of a stream
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      setBeat(0, 8'(120 + i), 28'd1 << 26, 2'b00);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("midreset out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("midreset res", res, 32'h0);
    checkOutput("midreset in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    postResetOutputs = 0;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("no stale beat", 32'(postResetOutputs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_norm_round.md
# fp_norm_round

Pipelined normalise-and-round stage downstream of the floating-point adder's align/add datapath. Consumes the raw, unnormalised sum (sign, biased exponent, extended mantissa with carry, guard, round and sticky bits, plus a special-case class) and produces a packed IEEE-754 result on `res`. The block is a 2-stage elastic pipeline with valid/ready handshakes on both sides, so the adder core can be stalled by its consumer without losing results.

## Interface
- `E_WIDTH`, default 8: exponent width.
- `M_WIDTH`, default 23: stored fraction width; the packed word is `E_WIDTH+M_WIDTH+1` bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts the beat this cycle.
- `in_sign` in 1: sign of the sum.
- `in_exp` in E_WIDTH: biased exponent, with the hidden bit at `in_mant[M_WIDTH+3]`.
- `in_mant` in M_WIDTH+5: bit layout is [M+4] carry, [M+3] hidden, [M+2:3] fraction, [2] guard, [1] round, [0] sticky.
- `in_class` in 2: 00 normal, 01 zero, 10 infinity, 11 NaN.
- `out_valid` out 1: `res` valid.
- `out_ready` in 1: consumer accepts `res`.
- `res` out E_WIDTH+M_WIDTH+1: packed result.

## Operation
- Stage 1 handles the leading-zero count over `in_mant[M+4:3]`, the shift direction and amount, the exponent adjust and class decode.
- Stage 2 applies the shift, then rounds and packs.
- If carry=1: shift right by 1, OR the bit shifted out into sticky, and exp+1.
- Else, with lz leading zeros below the carry: shift left by lz and exp−lz. Guard, round and sticky shift in with the mantissa; zeros fill from the bottom.
- If the normal class has a zero mantissa (exact cancellation), the result is +0 (sign forced to 0).
- Rounding is round-to-nearest-even. Increment when G & (R | S | LSB).
- If the rounding increment carries out, the fraction becomes 0 and exp+1.
- If the final exp is ≥ 2^E_WIDTH−1, the result is ±infinity (sign kept, exponent all ones, fraction 0).
- If exp would reach ≤ 0 after the left shift: the behaviour is set by `FP_SUBNORMAL_EN` (see Configuration).
- Class zero: {sign, 0, 0}. Class infinity: {sign, all ones, 0}.
- Class NaN: canonical quiet NaN {0, all ones, 1 followed by zeros}, i.e. 0x7FC00000 at the default widths.
- Intermediate exponent arithmetic is E_WIDTH+2 bits, signed.

## Timing
- Latency is 2 cycles from an accepted input to `out_valid`, with no stall.
- Throughput is 1 result per cycle.
- Stage 2 advances when `!s2_valid || out_ready`.
- Stage 1 advances when `!s1_valid || stage2 advances`.
- `in_ready` = stage 1 advance condition. It is combinational from `out_ready`.
- A transfer happens only on `valid && ready` at a clock edge.
- While `out_valid && !out_ready`, `res` holds stable.
- Up to 2 beats are buffered. Order is preserved with no drops or duplicates.
- Simultaneous output accept and input accept are both honoured in the same cycle.
- Reset values: `out_valid`=0, `res`=0, both stage valids 0. `in_ready`=0 while `rst`=0.
- Reset mid-operation discards in-flight beats. `in_ready`=1 on the first cycle after `rst` returns high.

## Configuration
- `FP_SUBNORMAL_EN` defined: gradual underflow.
  - If exp would drop to ≤ 0, the left shift is limited so exp=1, the mantissa is right-shifted as needed with sticky collection, the result is packed with exponent 0, and the result is RNE-rounded.
  - A round-up into the hidden position yields the minimum normal.
- `FP_SUBNORMAL_EN` undefined: any result with exp ≤ 0 flushes to ±0 (sign kept).

## Test plan
All vectors use E=8, M=23 (mant bit 27 = carry, 26 = hidden, 3 = LSB, 2 = guard).
- Identity: sign 0, exp 127, mant=1<<26 → `res`=0x3F800000, `out_valid` exactly 2 cycles after accept.
- Carry and left normalisation:
  - exp 127, mant=1<<27 → 0x40000000.
  - exp 127, mant=1<<24 → 0x3E800000.
  - normal class, mant=0, sign 1 → 0x00000000.
- RNE ties: exp 127:
  - mant=(1<<26)|(1<<3)|(1<<2) → 0x3F800002.
  - mant=(1<<26)|(1<<2) → 0x3F800000.
  - mant=(1<<26)|(1<<2)|1 → 0x3F800001.
- Specials and overflow:
  - exp 254, mant=1<<27 → 0x7F800000.
  - class 10, sign 1 → 0xFF800000.
  - class 11 → 0x7FC00000.
  - class 01, sign 1 → 0x80000000.
- Underflow: exp 1, mant=1<<25 → 0x00400000 with `FP_SUBNORMAL_EN`, 0x00000000 without.
- Backpressure and reset:
  - Stream 4 beats with `out_ready`=0 for 3 cycles → 2 accepted, then `in_ready`=0. Release gives all 4 results in order.
  - Assert `rst`=0 mid-stream → `out_valid`=0 and `res`=0 next cycle, with no stale beat emitted afterwards.
